// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte decoder: folds E0/F0 prefixes into key events, tracks held key,
// shift/caps state, and reports protocol/timeout errors and dropped events.
module ps2_key_event_ctrl #(
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic [7:0] press_cnt,
    output logic       shift,
    output logic       caps,
    output logic       err,
    output logic       ovf,
    input  logic       clr_flags,
    output logic [1:0] state_dbg
);
    // Event handshake: an event transfers on a cycle where ev_valid && ev_ready;
    // ev_* stay stable while ev_valid && !ev_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

    state_t      state, state_nxt;
    logic [23:0] tmo_cnt;
    logic        tmo_hit, done, proto_err;
    logic        done_ext, done_brk, is_press, held_match, is_repeat, drop;
    logic [8:0]  key, held_key;
    logic        held_valid, shift_l, shift_r;

    assign state_dbg = state;
    assign shift     = shift_l | shift_r;

    assign tmo_hit    = (state != IDLE) && !kbd_valid && (tmo_cnt == TIMEOUT - 24'd1);
    assign done_ext   = (state == EXT) || (state == EXT_BRK);
    assign done_brk   = (state == BRK) || (state == EXT_BRK);
    assign key        = {done_ext, kbd_code};
    assign is_press   = done && !done_brk;
    assign held_match = held_valid && (held_key == key);
    assign is_repeat  = is_press && held_match;
    assign drop       = done && ev_valid && !ev_ready;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        proto_err = 1'b0;
        if (tmo_hit) begin
            state_nxt = IDLE;
            proto_err = 1'b1;
        end else if (kbd_valid) begin
            if (kbd_code == 8'h00 || kbd_code == 8'hFF) begin
                state_nxt = IDLE;
                proto_err = 1'b1;
            end else if (kbd_code == 8'hE0) begin
                if (state == IDLE || state == EXT) begin
                    state_nxt = EXT;
                end else begin
                    state_nxt = IDLE;
                    proto_err = 1'b1;
                end
            end else if (kbd_code == 8'hF0) begin
                if (state == IDLE) begin
                    state_nxt = BRK;
                end else if (state == EXT) begin
                    state_nxt = EXT_BRK;
                end else begin
                    state_nxt = IDLE;
                    proto_err = 1'b1;
                end
            end else begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= IDLE;
            tmo_cnt    <= 24'd0;
            ev_valid   <= 1'b0;
            ev_code    <= 8'h00;
            ev_ext     <= 1'b0;
            ev_break   <= 1'b0;
            ev_repeat  <= 1'b0;
            press_cnt  <= 8'd0;
            held_key   <= 9'd0;
            held_valid <= 1'b0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nxt;
            // The prefix wait counter only runs while a prefix is pending.
            if (kbd_valid || state_nxt == IDLE) tmo_cnt <= 24'd0;
            else                                tmo_cnt <= tmo_cnt + 24'd1;

            if (done && !drop) begin
                ev_valid  <= 1'b1;
                ev_code   <= kbd_code;
                ev_ext    <= done_ext;
                ev_break  <= done_brk;
                ev_repeat <= is_repeat;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end

            if (is_press && !held_match) begin
                held_key   <= key;
                held_valid <= 1'b1;
                press_cnt  <= press_cnt + 8'd1;
            end else if (done && done_brk && held_match) begin
                held_valid <= 1'b0;
            end

            if (done && !done_ext && kbd_code == 8'h12) shift_l <= !done_brk;
            if (done && !done_ext && kbd_code == 8'h59) shift_r <= !done_brk;
            if (is_press && !is_repeat && !done_ext && kbd_code == 8'h58) caps <= !caps;

            if (proto_err)      err <= 1'b1;
            else if (clr_flags) err <= 1'b0;
            if (drop)           ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with hand-computed expectations.
module tb_ps2_key_event_ctrl;
    localparam logic [23:0] TMO = 24'd16;

    logic       clk = 1'b0;
    logic       clrn;
    logic       kbd_valid;
    logic [7:0] kbd_code;
    logic       ev_valid, ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_repeat;
    logic [7:0] press_cnt;
    logic       shift, caps, err, ovf, clr_flags;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    ps2_key_event_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .clrn(clrn), .kbd_valid(kbd_valid), .kbd_code(kbd_code),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat),
        .press_cnt(press_cnt), .shift(shift), .caps(caps), .err(err), .ovf(ovf),
        .clr_flags(clr_flags), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        kbd_valid = 1'b1;
        kbd_code  = b;
        @(negedge clk);
        kbd_valid = 1'b0;
        kbd_code  = 8'h00;
    endtask

    task automatic chk_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic brk, input logic rep);
        chk({tag, "_valid"}, ev_valid, 1);
        chk({tag, "_code"}, ev_code, code);
        chk({tag, "_ext"}, ev_ext, ext);
        chk({tag, "_brk"}, ev_break, brk);
        chk({tag, "_rep"}, ev_repeat, rep);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, ev_valid, 0);
        chk({tag, "_code"}, ev_code, 0);
        chk({tag, "_flags"}, {ev_ext, ev_break, ev_repeat}, 0);
        chk({tag, "_cnt"}, press_cnt, 0);
        chk({tag, "_sc"}, {shift, caps}, 0);
        chk({tag, "_eo"}, {err, ovf}, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        clrn = 1'b0; kbd_valid = 1'b0; kbd_code = 8'h00; ev_ready = 1'b1; clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        clrn = 1'b1;

        // press / release of 1C
        send(8'h1C); chk_ev("p1c", 8'h1C, 0, 0, 0); chk("p1c_cnt", press_cnt, 1);
        send(8'hF0); chk("brk_consumed", ev_valid, 0); chk("brk_state", state_dbg, 2);
        send(8'h1C); chk_ev("r1c", 8'h1C, 0, 1, 0); chk("r1c_cnt", press_cnt, 1);

        // extended press / release of 75
        send(8'hE0); chk("ext_state", state_dbg, 1);
        send(8'h75); chk_ev("p75", 8'h75, 1, 0, 0); chk("p75_cnt", press_cnt, 2);
        send(8'hE0); send(8'hF0); chk("extbrk_state", state_dbg, 3);
        send(8'h75); chk_ev("r75", 8'h75, 1, 1, 0);
        send(8'hE0); send(8'h75); chk_ev("p75b", 8'h75, 1, 0, 0);
        chk("held_cleared_cnt", press_cnt, 3);

        // typematic repeat
        send(8'h1C); chk_ev("rep0", 8'h1C, 0, 0, 0); chk("rep0_cnt", press_cnt, 4);
        send(8'h1C); chk_ev("rep1", 8'h1C, 0, 0, 1); chk("rep1_cnt", press_cnt, 4);
        send(8'h1C); chk_ev("rep2", 8'h1C, 0, 0, 1); chk("rep2_cnt", press_cnt, 4);
        send(8'hF0); send(8'h1C); chk_ev("rrel", 8'h1C, 0, 1, 0);
        @(negedge clk); chk("drain", ev_valid, 0);

        // backpressure: second event dropped, ovf set
        ev_ready = 1'b0;
        send(8'h1C); chk_ev("bp1", 8'h1C, 0, 0, 0); chk("bp1_cnt", press_cnt, 5);
        send(8'h32); chk_ev("bp2_hold", 8'h1C, 0, 0, 0);
        chk("bp2_ovf", ovf, 1); chk("bp2_cnt", press_cnt, 6);
        @(negedge clk); chk("bp_stable", ev_code, 8'h1C);
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        chk("ovf_clr", ovf, 0);
        ev_ready = 1'b1; @(negedge clk); chk("bp_drain", ev_valid, 0);

        // byte errors and set-over-clear priority
        send(8'h00); chk("e00_err", err, 1); chk("e00_noev", ev_valid, 0);
        @(negedge clk); clr_flags = 1'b1; kbd_valid = 1'b1; kbd_code = 8'hFF;
        @(negedge clk); clr_flags = 1'b0; kbd_valid = 1'b0; kbd_code = 8'h00;
        chk("prio_err", err, 1);
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        chk("err_clr", err, 0);

        // prefix timeout
        send(8'hE0); chk("tmo_pend", state_dbg, 1);
        repeat (TMO - 24'd3) @(negedge clk);
        chk("tmo_early", {err, state_dbg}, 3'b001);
        repeat (4) @(negedge clk);
        chk("tmo_state", state_dbg, 0); chk("tmo_err", err, 1); chk("tmo_noev", ev_valid, 0);
        send(8'h1C); chk_ev("tmo_ev", 8'h1C, 0, 0, 0); chk("tmo_cnt", press_cnt, 7);
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
        send(8'hF0); send(8'hF0);
        chk("ff_err", err, 1); chk("ff_noev", ev_valid, 0); chk("ff_state", state_dbg, 0);
        clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;

        // E0,E0 keeps the prefix without error
        send(8'hE0); send(8'hE0); chk("e0e0", {err, state_dbg}, 3'b001);
        send(8'h75); chk_ev("e0e0_ev", 8'h75, 1, 0, 0); chk("e0e0_cnt", press_cnt, 8);

        // shift / caps
        send(8'h12); chk("sh_on", shift, 1); chk("sh_cnt", press_cnt, 9);
        send(8'h58); chk("caps_on", caps, 1);
        send(8'hF0); send(8'h58); chk("caps_rel", caps, 1);
        send(8'h58); chk("caps_off", caps, 0); chk("caps_cnt", press_cnt, 11);
        chk("sh_held", shift, 1);
        send(8'hF0); send(8'h12); chk("sh_off", shift, 0);
        send(8'h59); chk("shr_on", shift, 1);
        send(8'hE0); send(8'hF0); send(8'h59); chk("shr_ext_ignored", shift, 1);

        // reset mid-prefix
        send(8'hE0); send(8'hF0);
        clrn = 1'b0; repeat (2) @(negedge clk);
        chk_zero("midrst");
        clrn = 1'b1;
        send(8'h1C); chk_ev("post_rst", 8'h1C, 0, 0, 0); chk("post_rst_cnt", press_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
